// File: rtl/dma_master_if.sv
// AXI-style master bus of dma_master: read address/data and write address/data/response channels.
// Every channel moves a beat on a rising edge where its VALID and READY are both high; VALID never waits on READY.
interface dma_master_if;
  logic [3:0]  M_ARID;
  logic [31:0] M_ARAddr;
  logic [3:0]  M_ARLen;
  logic [2:0]  M_ARSize;
  logic [1:0]  M_ARBurst;
  logic        M_ARValid;
  logic        M_ARReady;

  logic [3:0]  M_RID;
  logic [31:0] M_RData;
  logic [1:0]  M_RResp;
  logic        M_RLast;
  logic        M_RValid;
  logic        M_RReady;

  logic [3:0]  M_AWID;
  logic [31:0] M_AWAddr;
  logic [3:0]  M_AWLen;
  logic [2:0]  M_AWSize;
  logic [1:0]  M_AWBurst;
  logic        M_AWValid;
  logic        M_AWReady;

  logic [31:0] M_WData;
  logic [3:0]  M_WStrb;
  logic        M_WLast;
  logic        M_WValid;
  logic        M_WReady;

  logic [3:0]  M_BID;
  logic [1:0]  M_BResp;
  logic        M_BValid;
  logic        M_BReady;

  modport master (
    output M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid,
    input  M_ARReady,
    input  M_RID, M_RData, M_RResp, M_RLast, M_RValid,
    output M_RReady,
    output M_AWID, M_AWAddr, M_AWLen, M_AWSize, M_AWBurst, M_AWValid,
    input  M_AWReady,
    output M_WData, M_WStrb, M_WLast, M_WValid,
    input  M_WReady,
    input  M_BID, M_BResp, M_BValid,
    output M_BReady
  );

  modport slave (
    input  M_ARID, M_ARAddr, M_ARLen, M_ARSize, M_ARBurst, M_ARValid,
    output M_ARReady,
    output M_RID, M_RData, M_RResp, M_RLast, M_RValid,
    input  M_RReady,
    input  M_AWID, M_AWAddr, M_AWLen, M_AWSize, M_AWBurst, M_AWValid,
    output M_AWReady,
    input  M_WData, M_WStrb, M_WLast, M_WValid,
    output M_WReady,
    output M_BID, M_BResp, M_BValid,
    input  M_BReady
  );
endinterface

// File: rtl/dma_master.sv
// Memory-to-memory DMA: reads up to MAX_BURST words into a local buffer, then writes them out, chunk by chunk.
// Optional DMA_RESP_CHECK_EN: sticky DMA_err on bad RResp/BResp, aborting the transfer to DONE.
module dma_master #(
  parameter logic [3:0] DMA_ID    = 4'd0,
  parameter int         MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DMAEN,
  input  logic [31:0] DMASRC,
  input  logic [31:0] DMADST,
  input  logic [31:0] DMALEN,
  output logic        DMA_done,
  output logic        DMA_err,
  output logic [2:0]  dbg_state,
  dma_master_if.master m
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WDATA = 3'd4,
    WRESP = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] src, dst, remaining;
  logic [4:0]  cnt;
  logic        err_q;
  logic [31:0] data_buf [16];

  logic [4:0]  chunk;
  logic [3:0]  len_m1;
  logic        w_last;
  logic        r_bad, b_bad;
  logic        unused_ok;

  always_comb begin
    chunk  = (remaining > 32'(MAX_BURST)) ? 5'(MAX_BURST) : remaining[4:0];
    len_m1 = 4'(chunk - 5'd1);
    w_last = (cnt == chunk - 5'd1);
  end

`ifdef DMA_RESP_CHECK_EN
  assign r_bad     = (m.M_RResp != 2'b00);
  assign b_bad     = (m.M_BResp != 2'b00);
  assign unused_ok = ^{m.M_RID, m.M_BID, DMASRC[1:0], DMADST[1:0]};
`else
  assign r_bad     = 1'b0;
  assign b_bad     = 1'b0;
  assign unused_ok = ^{m.M_RID, m.M_BID, DMASRC[1:0], DMADST[1:0], m.M_RResp, m.M_BResp};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    m.M_ARID    = DMA_ID;
    m.M_ARAddr  = 32'd0;
    m.M_ARLen   = 4'd0;
    m.M_ARSize  = 3'b000;
    m.M_ARBurst = 2'b00;
    m.M_ARValid = 1'b0;
    m.M_RReady  = 1'b0;
    m.M_AWID    = DMA_ID;
    m.M_AWAddr  = 32'd0;
    m.M_AWLen   = 4'd0;
    m.M_AWSize  = 3'b000;
    m.M_AWBurst = 2'b00;
    m.M_AWValid = 1'b0;
    m.M_WData   = 32'd0;
    m.M_WStrb   = 4'h0;
    m.M_WLast   = 1'b0;
    m.M_WValid  = 1'b0;
    m.M_BReady  = 1'b0;
    DMA_done    = 1'b0;
    case (state)
      IDLE: begin
        if (DMAEN) state_nxt = (DMALEN != 32'd0) ? RADDR : DONE;
      end
      RADDR: begin
        m.M_ARValid = 1'b1;
        m.M_ARAddr  = src;
        m.M_ARLen   = len_m1;
        m.M_ARSize  = 3'b010;
        m.M_ARBurst = 2'b01;
        if (m.M_ARReady) state_nxt = RDATA;
      end
      RDATA: begin
        m.M_RReady = 1'b1;
        // A bad response still drains the burst; the write side is skipped afterwards.
        if (m.M_RValid && m.M_RLast) state_nxt = (err_q || r_bad) ? DONE : WADDR;
      end
      WADDR: begin
        m.M_AWValid = 1'b1;
        m.M_AWAddr  = dst;
        m.M_AWLen   = len_m1;
        m.M_AWSize  = 3'b010;
        m.M_AWBurst = 2'b01;
        if (m.M_AWReady) state_nxt = WDATA;
      end
      WDATA: begin
        m.M_WValid = 1'b1;
        m.M_WData  = data_buf[cnt[3:0]];
        m.M_WStrb  = 4'hF;
        m.M_WLast  = w_last;
        if (m.M_WReady && w_last) state_nxt = WRESP;
      end
      WRESP: begin
        m.M_BReady = 1'b1;
        if (m.M_BValid) begin
          if (b_bad || remaining == {27'd0, chunk}) state_nxt = DONE;
          else                                      state_nxt = RADDR;
        end
      end
      DONE: begin
        DMA_done = 1'b1;
        if (!DMAEN) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src       <= 32'd0;
      dst       <= 32'd0;
      remaining <= 32'd0;
      cnt       <= 5'd0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (DMAEN) begin
            src       <= {DMASRC[31:2], 2'b00};
            dst       <= {DMADST[31:2], 2'b00};
            remaining <= DMALEN;
            cnt       <= 5'd0;
            if (DMALEN != 32'd0) err_q <= 1'b0;
          end
        end
        RDATA: begin
          if (m.M_RValid) begin
            if (r_bad) err_q <= 1'b1;
            // Beats beyond the chunk are absorbed; cnt saturates so it never wraps into the buffer.
            if (m.M_RLast)          cnt <= 5'd0;
            else if (cnt != 5'd16)  cnt <= cnt + 5'd1;
          end
        end
        WDATA: begin
          if (m.M_WReady) cnt <= w_last ? 5'd0 : cnt + 5'd1;
        end
        WRESP: begin
          if (m.M_BValid) begin
            if (b_bad) err_q <= 1'b1;
            src       <= src + {25'd0, chunk, 2'b00};
            dst       <= dst + {25'd0, chunk, 2'b00};
            remaining <= remaining - {27'd0, chunk};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == RDATA && m.M_RValid && cnt < chunk) data_buf[cnt[3:0]] <= m.M_RData;
  end

  assign DMA_err   = err_q;
  assign dbg_state = state;

endmodule

// File: doc/dma_master.md
DMA_MASTER -- requirements
Module: dma_master

Interface
REQ-001 SHALL have parameter DMA_ID, default 4'd0, ID driven on ARID/AWID.
REQ-002 SHALL have parameter MAX_BURST, default 16, max beats per burst (legal 1..16).
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port DMAEN  in  1  start/enable, level.
REQ-006 SHALL have port DMASRC  in  32  source byte address.
REQ-007 SHALL have port DMADST  in  32  destination byte address.
REQ-008 SHALL have port DMALEN  in  32  transfer length in 32-bit words.
REQ-009 SHALL have port DMA_done  out  1  transfer complete, level.
REQ-010 SHALL have port DMA_err  out  1  response error flag.
REQ-011 SHALL have ports M_ARID 4, M_ARAddr 32, M_ARLen 4, M_ARSize 3, M_ARBurst 2 and M_ARValid 1 as outputs, and M_ARReady 1 as input.
REQ-012 SHALL have ports M_RID 4, M_RData 32, M_RResp 2, M_RLast 1 and M_RValid 1 as inputs, and M_RReady 1 as output.
REQ-013 SHALL have ports M_AWID 4, M_AWAddr 32, M_AWLen 4, M_AWSize 3, M_AWBurst 2 and M_AWValid 1 as outputs, and M_AWReady 1 as input.
REQ-014 SHALL have ports M_WData 32, M_WStrb 4, M_WLast 1 and M_WValid 1 as outputs, and M_WReady 1 as input.
REQ-015 SHALL have ports M_BID 4, M_BResp 2 and M_BValid 1 as inputs, and M_BReady 1 as output.

Function
REQ-016 SHALL implement FSM states IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE.
REQ-017 In IDLE with DMAEN=1, SHALL latch DMASRC/DMADST with bits[1:0] forced 0 and latch DMALEN as remaining.
REQ-018 In IDLE with DMAEN=1, SHALL go to RADDR if DMALEN!=0, else to DONE.
REQ-019 SHALL compute chunk = min(remaining, MAX_BURST); ARLen = AWLen = chunk-1; ARSize = AWSize = 3'b010; ARBurst = AWBurst = 2'b01 (INCR).
REQ-020 SHALL assert M_ARValid exactly while in RADDR, hold ARAddr/ARLen stable until handshake, then go to RDATA.
REQ-021 SHALL assert M_RReady in RDATA and write each accepted beat to a 16x32 buffer at index cnt, where cnt increments per beat.
REQ-022 SHALL end RDATA on the beat with RLast=1, clear cnt and go to WADDR; beats past chunk SHALL be accepted and discarded.
REQ-023 SHALL assert M_AWValid exactly while in WADDR, then go to WDATA on handshake.
REQ-024 In WDATA, SHALL assert M_WValid with WData = buf[cnt], WStrb = 4'hF and WLast = (cnt == chunk-1).
REQ-025 SHALL hold WData/WLast stable until WReady and go to WRESP after the last-beat handshake.
REQ-026 SHALL assert M_BReady in WRESP.
REQ-027 On B handshake, SHALL add 4*chunk to src and dst, subtract chunk from remaining, and go to DONE if remaining becomes 0, else to RADDR.
REQ-028 In DONE, SHALL hold DMA_done=1 and return to IDLE when DMAEN=0; DMA_done SHALL drop on the cycle after IDLE entry.
REQ-029 SHALL ignore DMAEN deassertion mid-transfer; in-flight bursts always complete.
REQ-030 SHALL ignore RID/BID.
REQ-031 SHALL assert ARValid the cycle after DMAEN is sampled in IDLE.
REQ-032 Software SHALL NOT place a burst that crosses a 4 KB boundary; the block does not split such bursts.

Reset
REQ-033 On rst=1 at posedge, SHALL go to IDLE and clear cnt, remaining, src, dst, DMA_done and DMA_err.
REQ-034 On rst=1 at posedge, SHALL drive all M_*Valid/M_*Ready to 0 and all address/len fields to 0.
REQ-035 Reset mid-burst SHALL abandon the transaction without completing handshakes.

Configuration
REQ-036 With DMA_RESP_CHECK_EN defined, SHALL set DMA_err sticky on any RResp/BResp != 2'b00.
REQ-037 With DMA_RESP_CHECK_EN defined, after a bad RResp SHALL finish accepting the read burst, skip write phases and go to DONE.
REQ-038 With DMA_RESP_CHECK_EN defined, after a bad BResp SHALL go to DONE.
REQ-039 With DMA_RESP_CHECK_EN defined, DMA_err SHALL clear on the next IDLE->RADDR start.
REQ-040 Without DMA_RESP_CHECK_EN, SHALL ignore responses and tie DMA_err to 0.

Verification
REQ-041 SHALL verify DMALEN=1, SRC=0x1000_0000, DST=0x2000_0000, RData=0xDEADBEEF -> ARLen=0, AWLen=0, WData=0xDEADBEEF with WLast=1 and WStrb=F, DMA_done=1 cycle after B.
REQ-042 SHALL verify DMALEN=20, SRC=0x1000_0000 -> ARLen=15 @0x1000_0000, ARLen=3 @0x1000_0040, with writes at the matching DST offsets.
REQ-043 SHALL verify ARReady delayed 5 cycles and WReady toggling 1/0 -> ARValid held with address stable, 16 W beats in order, no beat lost.
REQ-044 SHALL verify DMAEN=1 with DMALEN=0 -> DONE next cycle, no Valid asserted, DMA_done=1; DMAEN=0 -> IDLE.
REQ-045 SHALL verify rst=1 during RDATA beat 3 -> next cycle all Valid/Ready 0, IDLE, DMA_done=0.
REQ-046 SHALL verify, with DMA_RESP_CHECK_EN, RResp=2'b10 on beat 2 of 4 -> 4 beats accepted, no AWValid, DMA_err=1 and DMA_done=1.
